if_fetch_queue: RTL and testbench

Parametrised instruction-fetch stage for the pipelined RV32I core. It owns the program counter and reads the instruction memory combinationally. It buffers fetched {pc, instruction} pairs in a small FIFO and hands them to decode over a valid/ready handshake. Branch and jump redirects from execute flush the queue and retarget the PC. This replaces the free-running PC register plus adder of the single-cycle datapath.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 53 +++++
 rtl/if_fetch_queue.sv | 88 ++++++++
 tb/tb_if_fetch_queue.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I core constants and fetch entry type
package riscv_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO holding fetched {pc, inst} entries
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   push, pop      write tail / retire head (caller guarantees legality)
//   flush          empties the queue, overrides push and pop
//   wdata, rdata   entry in / head entry out (zero when empty)
//   count          occupied entries
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;

  // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = (count_q == '0) ? '0 : mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch stage with PC, redirect and fetch queue
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   fetch_en                   allows a fetch this cycle
//   imem_addr, imem_rdata      combinational instruction memory word port
//   redirect_valid/_pc         flush queue and retarget pc
//   id_valid/_ready            head handshake to decode
//   id_inst, id_pc, id_pc4     head entry (zero when empty)
//   q_count                    occupied queue entries
//   misalign_err               sticky: a redirect target had pc[1:0] != 0
module if_fetch_queue
  import riscv_pkg::*;
#(
  parameter int               XLEN     = XLEN_DEFAULT,
  parameter int               DEPTH    = 4,
  parameter int               IMEM_AW  = 6,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_en,
  output logic [IMEM_AW-1:0]         imem_addr,
  input  logic [XLEN-1:0]            imem_rdata,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [XLEN-1:0]            id_inst,
  output logic [XLEN-1:0]            id_pc,
  output logic [XLEN-1:0]            id_pc4,
  output logic [$clog2(DEPTH):0]     q_count,
  output logic                       misalign_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]   pc;
  logic              push;
  logic              pop;
  logic              full;
  logic [2*XLEN-1:0] head;

  assign imem_addr = pc[IMEM_AW+1:2];

  // id_valid comes from the registered count only, never from id_ready.
  assign id_valid = (q_count != '0);
  assign pop      = id_valid & id_ready;
  assign full     = (q_count == CW'(DEPTH));
  // A pop frees the slot in the same cycle, so a full queue still accepts.
  assign push     = fetch_en & ~redirect_valid & (~full | pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[XLEN-1:2], 2'b00};
    end else if (push) begin
      pc <= pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_err <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      misalign_err <= 1'b1;
    end
  end

  fetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({pc, imem_rdata}),
    .rdata (head),
    .count (q_count)
  );

  assign id_pc   = head[2*XLEN-1:XLEN];
  assign id_inst = head[XLEN-1:0];
  assign id_pc4  = id_valid ? id_pc + XLEN'(4) : '0;

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - self-checking bench for if_fetch_queue
module tb_if_fetch_queue;
  import riscv_pkg::*;

  localparam int DEPTH   = 4;
  localparam int IMEM_AW = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_en = 1'b0;
  logic [29:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [2:0]  q_count;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [29:0] a);
    return {a, 2'b11} ^ 32'h5A3C_0000;
  endfunction

  assign imem_rdata = imem_word(imem_addr);

  if_fetch_queue #(
    .XLEN(32), .DEPTH(DEPTH), .IMEM_AW(IMEM_AW), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4),
    .q_count(q_count), .misalign_err(misalign_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of {pc, inst} entries plus the fetch pointer.
  fetch_entry_t mq[$];
  logic [31:0]  mpc = 32'h0;
  logic         mmis = 1'b0;

  initial begin
    int n;
    bit pp;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mq.delete();
        mpc  = 32'h0;
        mmis = 1'b0;
      end else begin
        n  = mq.size();
        pp = (n > 0) && id_ready;
        if (redirect_valid) begin
          mq.delete();
          mpc = {redirect_pc[31:2], 2'b00};
          if (redirect_pc[1:0] != 2'b00) mmis = 1'b1;
        end else begin
          if (pp) void'(mq.pop_front());
          if (fetch_en && (n < DEPTH || pp)) begin
            mq.push_back('{pc: mpc, inst: imem_word(mpc[31:2])});
            mpc = mpc + 32'd4;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("m_valid", {31'b0, id_valid}, {31'b0, mq.size() > 0});
      check("m_count", {29'b0, q_count}, 32'(mq.size()));
      check("m_pc",    id_pc,   (mq.size() > 0) ? mq[0].pc : 32'h0);
      check("m_inst",  id_inst, (mq.size() > 0) ? mq[0].inst : 32'h0);
      check("m_pc4",   id_pc4,  (mq.size() > 0) ? mq[0].pc + 32'd4 : 32'h0);
      check("m_addr",  {2'b0, imem_addr}, {2'b0, mpc[31:2]});
      check("m_mis",   {31'b0, misalign_err}, {31'b0, mmis});
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_valid", {31'b0, id_valid}, 32'd0);
    check("rst_count", {29'b0, q_count}, 32'd0);
    check("rst_pc4", id_pc4, 32'd0);

    // Streaming from RESET_PC with decode always ready
    fetch_en = 1'b1;
    id_ready = 1'b1;
    do_reset();
    cyc();
    for (int i = 0; i < 4; i++) begin
      check("stream_pc",  id_pc,  32'(4 * i));
      check("stream_pc4", id_pc4, 32'(4 * i + 4));
      check("stream_cnt", {29'b0, q_count}, 32'd1);
      cyc();
    end

    // Stall until full, then drain in order
    id_ready = 1'b0;
    do_reset();
    repeat (8) cyc();
    check("full_cnt",  {29'b0, q_count}, 32'd4);
    check("full_addr", {2'b0, imem_addr}, 32'd4);
    id_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("drain_pc", id_pc, 32'(4 * i));
      cyc();
    end

    // Redirect with three entries queued
    id_ready = 1'b0;
    do_reset();
    repeat (3) cyc();
    check("pre_redir_cnt", {29'b0, q_count}, 32'd3);
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    cyc();
    redirect_valid = 1'b0;
    check("bubble_valid", {31'b0, id_valid}, 32'd0);
    cyc();
    check("redir_pc0", id_pc, 32'h40);
    cyc();
    check("redir_pc1", id_pc, 32'h44);

    // Misaligned redirect, stickiness
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    cyc();
    redirect_valid = 1'b0;
    check("mis_set",  {31'b0, misalign_err}, 32'd1);
    check("mis_addr", {2'b0, imem_addr}, 32'h10);
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    check("mis_sticky", {31'b0, misalign_err}, 32'd1);

    // PC wrap-around at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    check("wrap_pc",   id_pc,   32'hFFFF_FFFC);
    check("wrap_pc4",  id_pc4,  32'h0);
    check("wrap_inst", id_inst, 32'hA5C3_FFFF);
    cyc();
    check("wrap_pc_next", id_pc, 32'h0);

    do_reset();
    check("mis_clear", {31'b0, misalign_err}, 32'd0);

    // Asynchronous reset with the queue full
    id_ready = 1'b0;
    repeat (6) cyc();
    check("async_pre_cnt", {29'b0, q_count}, 32'd4);
    #2;
    rst = 1'b0;
    #1;
    check("async_valid", {31'b0, id_valid}, 32'd0);
    check("async_cnt",   {29'b0, q_count}, 32'd0);
    check("async_addr",  {2'b0, imem_addr}, 32'd0);
    cyc();
    rst      = 1'b1;
    id_ready = 1'b1;
    cyc();
    check("restart_pc", id_pc, 32'h0);
    cyc();
    check("restart_pc1", id_pc, 32'h4);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
